adlib_env_mix: RTL and testbench
================================

# adlib_env_mix

Envelope and mixing stage that sits directly downstream of the AdLib oscillator pair. It consumes the two operator magnitude/sign streams and the key-on `play` flag. For each operator it runs an attack/decay/sustain/release envelope, then applies the envelope and a total-level gain. The two operators are summed into one signed PCM sample for the DAC/PWM output stage.

## Interface
Parameters:
- `ENV_TICK_DIV`, default 1500: clk cycles per envelope tick (75 MHz / 1500 = 50 kHz).

Ports:
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `din` in 8: register write data.
- `wr_ad` in 2: bit n writes the op(n+1) AD register: `[7:4]` attack rate, `[3:0]` decay rate.
- `wr_sr` in 2: bit n writes the op(n+1) SR register: `[7:4]` sustain level, `[3:0]` release rate.
- `wr_tl` in 2: bit n writes the op(n+1) TL register: `din[5:0]` total-level attenuation.
- `play` in 1: key-on, level-sensitive.
- `neg1` in 1, `value1` in 4: operator 1 sign and magnitude.
- `neg2` in 1, `value2` in 4: operator 2 sign and magnitude.
- `sample` out 12: signed sum of both operators.
- `env_active` out 1: high while either envelope is not IDLE.

## Operation
- Tick divider: a counter counts 0..ENV_TICK_DIV-1 and wraps. `tick` is a one-cycle pulse on the wrap.
- Key-on edge detection: `play` is registered once.
  - rise = `play & ~play_q`: both envelopes go to ATTACK and their step counters clear. `env` is not cleared; attack resumes from the current level.
  - fall: every envelope in ATTACK, DECAY or SUSTAIN goes to RELEASE and its step counter clears.
- Rate stepping, per operator, using a 15-bit step counter that increments on each `tick`:
  - For rate r in 1..15: `mask = (1<<(15-r))-1`. A step occurs on a tick when `(cnt & mask) == mask`, so r=15 steps every tick and r=1 steps every 16384 ticks.
  - r=0: the envelope never steps.
- `env` is 6-bit unsigned, 0..63. Envelope states:
  - IDLE: `env`=0.
  - ATTACK: `env`+1 per step. When it reaches 63, go to DECAY.
  - DECAY: `env`−1 per step down to `target = 63 − 4*SL`. When `env <= target`, go to SUSTAIN. Entering DECAY with `env` already ≤ target goes straight to SUSTAIN.
  - SUSTAIN: hold while `play`=1.
  - RELEASE: `env`−1 per step. When it reaches 0, go to IDLE.
- Step counters clear on every state transition.
- Gain: `g = 63 − TL`.
- Datapath: `p = value*env` (10b), then `m = (p*g) >> 6` (10b unsigned, max 930). Apply `neg` to form an 11-bit signed operand. `sample = op1 + op2`, range ±1860.
- Register write landing on a tick cycle: the new value takes effect from the next tick. The current step uses the old value.
- Key edge coinciding with a tick: the state transition wins and no env step occurs in that cycle.
- `rst` mid-operation: all state returns to reset values on the next clock edge.

## Timing
- Reset values:
  - `sample`=0, `env_active`=0.
  - Both envelopes IDLE with `env`=0.
  - All AD/SR/TL registers 0, step counters 0, tick divider 0, `play_q`=0.
- Key-on edge: `play` rising at edge k produces an envelope state change visible at edge k+2 (1 cycle to register, 1 cycle to transition).
- Datapath latency: 3 cycles, registered at each stage.
  - Stage 1: product `p`.
  - Stage 2: gain and shift.
  - Stage 3: sign and sum.
  - `value`/`neg` at edge k appear in `sample` at edge k+3.
- `env` is sampled into stage 1 in the same cycle as `value`.
- `env_active` is registered and lags state by 1 cycle.

## Configuration
- `ADLIB_ENV_INSTANT_ATTACK_EN`:
  - Defined: attack rate 15 sets `env`=63 on the first tick after entering ATTACK, and the envelope moves to DECAY on the following tick.
  - Undefined: rate 15 ramps +1 per tick, so it takes 63 ticks to reach 63.
  - Attack rates 1..14 are unaffected either way.

## Structure
- Package `adlib_pkg` holds:
  - `env_state_t` enum: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
  - `ENV_MAX`=63.
  - Step-mask helper function.
- Sub-module `adlib_env_gen`, instantiated once per operator:
  - Contains the AD/SR registers, FSM, step counter and `env` output.
  - Takes `tick`, `key_rise` and `key_fall` as inputs.
- The top level owns the tick divider, key edge detection, TL registers and the 3-stage mix pipeline.

## Test plan
All scenarios run with `ENV_TICK_DIV`=4.
- Reset: assert `rst` mid-attack → `sample`=0, `env_active`=0 on the next cycle; subsequent `value` inputs produce `sample`=0 until key-on.
- Attack: op1 AD=0xF0, TL=0, `value1`=15, `neg1`=0, op2 `value2`=0; raise `play` → op1 `env` reaches 63 after 63 ticks and `sample`=930 three cycles later. With the macro defined it reaches 63 after 1 tick.
- Sign and sum: both operators at `env`=63 with `value`=15 → `sample`=1860. Set `neg1`=1 → `sample`=0. Set `neg1`=`neg2`=1 → `sample`=−1860.
- Decay/sustain: AD=0xFF, SR=0x80 → `env` 0→63, then 63→31, then holds 31 in SUSTAIN while `play`=1.
- Release: SR=0x8F, drop `play` while in SUSTAIN → `env` decrements 1 per tick to 0 in 31 ticks, then IDLE; `env_active` falls 1 cycle later.
- Total level: TL=63 on both operators with full envelopes → `sample`=0. TL=32 on op1 only (op2 `value2`=0) → `sample`=(945*31)>>6=457.

Source files
------------

// File: rtl/adlib_pkg.sv
// Shared types and helpers for the AdLib envelope/mix stage.
package adlib_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } env_state_t;

    localparam logic [5:0] ENV_MAX = 6'd63;

    // Rate r steps when the low (15-r) counter bits are all ones.
    function automatic logic [14:0] step_mask(input logic [3:0] rate);
        logic [15:0] full;
        full = (16'd1 << (5'd15 - {1'b0, rate})) - 16'd1;
        return full[14:0];
    endfunction

endpackage

// File: rtl/adlib_env_gen.sv
// Per-operator ADSR envelope: AD/SR registers, state machine, step counter.
// ADLIB_ENV_INSTANT_ATTACK_EN: attack rate 15 jumps straight to full level.
//
// state   | meaning
// IDLE    | silent, env held at 0
// ATTACK  | env rising toward ENV_MAX
// DECAY   | env falling toward the sustain target
// SUSTAIN | env held while key is down
// RELEASE | env falling toward 0 after key-up
module adlib_env_gen
    import adlib_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       key_rise,
    input  logic       key_fall,
    input  logic [7:0] din,
    input  logic       wr_ad,
    input  logic       wr_sr,
    output logic [5:0] env,
    output env_state_t state
);

    logic [7:0]  ad_reg;
    logic [7:0]  sr_reg;
    logic [14:0] step_cnt;
    logic [3:0]  rate;
    logic [14:0] mask;
    logic        step;
    logic        step_clr;
    logic        instant_attack;
    logic [5:0]  target;
    logic [5:0]  env_inc;
    logic [5:0]  env_dec;
    env_state_t  state_nxt;
    logic [5:0]  env_nxt;

`ifdef ADLIB_ENV_INSTANT_ATTACK_EN
    assign instant_attack = (ad_reg[7:4] == 4'hF);
`else
    assign instant_attack = 1'b0;
`endif

    assign target  = ENV_MAX - {sr_reg[7:4], 2'b00};
    assign env_inc = env + 6'd1;
    assign env_dec = env - 6'd1;

    always_comb begin
        rate = 4'd0;
        case (state)
            ATTACK:  rate = ad_reg[7:4];
            DECAY:   rate = ad_reg[3:0];
            RELEASE: rate = sr_reg[3:0];
            default: rate = 4'd0;
        endcase
    end

    assign mask = step_mask(rate);
    assign step = tick && (rate != 4'd0) && ((step_cnt & mask) == mask);

    // Key edges take priority over any step landing in the same cycle.
    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        if (key_rise) begin
            state_nxt = ATTACK;
        end else if (key_fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
            state_nxt = RELEASE;
        end else begin
            case (state)
                IDLE: env_nxt = '0;
                ATTACK: begin
                    if (instant_attack) begin
                        if (tick && env == ENV_MAX) state_nxt = DECAY;
                        else if (step)              env_nxt   = ENV_MAX;
                    end else if (env == ENV_MAX) begin
                        state_nxt = DECAY;
                    end else if (step) begin
                        env_nxt = env_inc;
                        if (env_inc == ENV_MAX) state_nxt = DECAY;
                    end
                end
                DECAY: begin
                    if (env <= target) begin
                        state_nxt = SUSTAIN;
                    end else if (step) begin
                        env_nxt = env_dec;
                        if (env_dec <= target) state_nxt = SUSTAIN;
                    end
                end
                SUSTAIN: state_nxt = SUSTAIN;
                RELEASE: begin
                    if (env == 6'd0) begin
                        state_nxt = IDLE;
                    end else if (step) begin
                        env_nxt = env_dec;
                        if (env_dec == 6'd0) state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign step_clr = key_rise || (state_nxt != state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            env      <= '0;
            step_cnt <= '0;
            ad_reg   <= '0;
            sr_reg   <= '0;
        end else begin
            state <= state_nxt;
            env   <= env_nxt;
            if (step_clr)  step_cnt <= '0;
            else if (tick) step_cnt <= step_cnt + 15'd1;
            if (wr_ad) ad_reg <= din;
            if (wr_sr) sr_reg <= din;
        end
    end

endmodule

// File: rtl/adlib_env_mix.sv
// Envelope and mix stage: tick divider, key edge detect, TL gain and a
// 3-stage pipeline summing both operators into one signed PCM sample.
module adlib_env_mix
    import adlib_pkg::*;
#(
    parameter int ENV_TICK_DIV = 1500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         din,
    input  logic [1:0]         wr_ad,
    input  logic [1:0]         wr_sr,
    input  logic [1:0]         wr_tl,
    input  logic               play,
    input  logic               neg1,
    input  logic [3:0]         value1,
    input  logic               neg2,
    input  logic [3:0]         value2,
    output logic signed [11:0] sample,
    output logic               env_active
);

    localparam int DIV_W = (ENV_TICK_DIV > 1) ? $clog2(ENV_TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ENV_TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             play_q;
    logic             key_rise;
    logic             key_fall;
    logic [5:0]       tl1, tl2;
    logic [5:0]       env1, env2;
    env_state_t       st1, st2;

    logic [9:0]  p1, p2;
    logic        n1_s1, n2_s1;
    logic [9:0]  m1, m2;
    logic        n1_s2, n2_s2;
    logic [5:0]  g1, g2;
    logic [15:0] pg1, pg2;
    logic [10:0] op1, op2;

    assign tick = (div_cnt == DIV_LAST);

    // Key edges are registered so a play change lands two edges later.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            play_q   <= 1'b0;
            key_rise <= 1'b0;
            key_fall <= 1'b0;
            tl1      <= '0;
            tl2      <= '0;
        end else begin
            div_cnt  <= tick ? '0 : div_cnt + DIV_W'(1);
            play_q   <= play;
            key_rise <= play & ~play_q;
            key_fall <= ~play & play_q;
            if (wr_tl[0]) tl1 <= din[5:0];
            if (wr_tl[1]) tl2 <= din[5:0];
        end
    end

    adlib_env_gen u_env1 (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .key_rise (key_rise),
        .key_fall (key_fall),
        .din      (din),
        .wr_ad    (wr_ad[0]),
        .wr_sr    (wr_sr[0]),
        .env      (env1),
        .state    (st1)
    );

    adlib_env_gen u_env2 (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .key_rise (key_rise),
        .key_fall (key_fall),
        .din      (din),
        .wr_ad    (wr_ad[1]),
        .wr_sr    (wr_sr[1]),
        .env      (env2),
        .state    (st2)
    );

    assign g1  = ENV_MAX - tl1;
    assign g2  = ENV_MAX - tl2;
    assign pg1 = 16'(p1) * 16'(g1);
    assign pg2 = 16'(p2) * 16'(g2);
    assign op1 = n1_s2 ? (~{1'b0, m1} + 11'd1) : {1'b0, m1};
    assign op2 = n2_s2 ? (~{1'b0, m2} + 11'd1) : {1'b0, m2};

    always_ff @(posedge clk) begin
        if (rst) begin
            p1         <= '0;
            p2         <= '0;
            n1_s1      <= 1'b0;
            n2_s1      <= 1'b0;
            m1         <= '0;
            m2         <= '0;
            n1_s2      <= 1'b0;
            n2_s2      <= 1'b0;
            sample     <= '0;
            env_active <= 1'b0;
        end else begin
            p1         <= 10'(value1) * 10'(env1);
            p2         <= 10'(value2) * 10'(env2);
            n1_s1      <= neg1;
            n2_s1      <= neg2;
            m1         <= pg1[15:6];
            m2         <= pg2[15:6];
            n1_s2      <= n1_s1;
            n2_s2      <= n2_s1;
            sample     <= {op1[10], op1} + {op2[10], op2};
            env_active <= (st1 != IDLE) || (st2 != IDLE);
        end
    end

endmodule

// File: tb/tb_adlib_env_mix.sv
// Directed self-checking bench for adlib_env_mix with ENV_TICK_DIV=4.
module tb_adlib_env_mix;
    import adlib_pkg::*;

    localparam int DIV = 4;
`ifdef ADLIB_ENV_INSTANT_ATTACK_EN
    localparam int ATK_TICKS  = 1;
    localparam int DEC_TICKS  = 33;
    localparam int PRE_SAMPLE = 0;
`else
    localparam int ATK_TICKS  = 63;
    localparam int DEC_TICKS  = 32;
    localparam int PRE_SAMPLE = 915;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         din = '0;
    logic [1:0]         wr_ad = '0, wr_sr = '0, wr_tl = '0;
    logic               play = 1'b0;
    logic               neg1 = 1'b0, neg2 = 1'b0;
    logic [3:0]         value1 = '0, value2 = '0;
    logic signed [11:0] sample;
    logic               env_active;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int mdiv      = 0;
    int mticks    = 0;

    always #5 clk = ~clk;

    adlib_env_mix #(.ENV_TICK_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .wr_ad      (wr_ad),
        .wr_sr      (wr_sr),
        .wr_tl      (wr_tl),
        .play       (play),
        .neg1       (neg1),
        .value1     (value1),
        .neg2       (neg2),
        .value2     (value2),
        .sample     (sample),
        .env_active (env_active)
    );

    // Independent tick model: counts envelope ticks since reset.
    always @(posedge clk) begin
        if (rst) mdiv <= 0;
        else if (mdiv == DIV - 1) begin
            mdiv   <= 0;
            mticks <= mticks + 1;
        end else mdiv <= mdiv + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1; din = '0; wr_ad = '0; wr_sr = '0; wr_tl = '0;
        play = 1'b0; neg1 = 1'b0; neg2 = 1'b0; value1 = '0; value2 = '0;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic write_reg(input int which, input logic [1:0] mask, input logic [7:0] data);
        din = data;
        case (which)
            0:       wr_ad = mask;
            1:       wr_sr = mask;
            default: wr_tl = mask;
        endcase
        cycles(1);
        wr_ad = '0; wr_sr = '0; wr_tl = '0;
    endtask

    task automatic wait_env1(input logic [5:0] v, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (dut.u_env1.env == v) begin ok = 1'b1; break; end
            cycles(1);
        end
    endtask

    task automatic wait_state1(input env_state_t s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (dut.u_env1.state == s) begin ok = 1'b1; break; end
            cycles(1);
        end
    endtask

    task automatic test_reset;
        do_reset;
        total_cnt++; if (sample !== 12'sd0) $display("FAIL reset_sample: got %0d want 0", sample); else pass_cnt++;
        total_cnt++; if (env_active !== 1'b0) $display("FAIL reset_active: got %b want 0", env_active); else pass_cnt++;
        write_reg(0, 2'b11, 8'hF0);
        value1 = 4'd15; value2 = 4'd15; play = 1'b1;
        cycles(82);
        total_cnt++; if (dut.u_env1.env == 6'd0) $display("FAIL reset_preattack_env: got %0d want nonzero", dut.u_env1.env); else pass_cnt++;
        rst = 1'b1; play = 1'b0;
        cycles(1);
        total_cnt++; if (sample !== 12'sd0) $display("FAIL reset_mid_sample: got %0d want 0", sample); else pass_cnt++;
        total_cnt++; if (env_active !== 1'b0) $display("FAIL reset_mid_active: got %b want 0", env_active); else pass_cnt++;
        total_cnt++; if (dut.u_env1.env !== 6'd0) $display("FAIL reset_mid_env: got %0d want 0", dut.u_env1.env); else pass_cnt++;
        rst = 1'b0;
        cycles(10);
        total_cnt++; if (sample !== 12'sd0) $display("FAIL reset_post_sample: got %0d want 0", sample); else pass_cnt++;
        play = 1'b1;
        cycles(40);
        total_cnt++; if (env_active !== 1'b1) $display("FAIL reset_rate0_active: got %b want 1", env_active); else pass_cnt++;
        total_cnt++; if (dut.u_env1.env !== 6'd0) $display("FAIL reset_rate0_env: got %0d want 0", dut.u_env1.env); else pass_cnt++;
        total_cnt++; if (sample !== 12'sd0) $display("FAIL reset_rate0_sample: got %0d want 0", sample); else pass_cnt++;
    endtask

    task automatic test_attack;
        bit ok;
        int t0;
        do_reset;
        write_reg(0, 2'b11, 8'hF0);
        value1 = 4'd15; value2 = 4'd0;
        play = 1'b1;
        cycles(1);
        total_cnt++; if (dut.u_env1.state !== IDLE) $display("FAIL keyon_early: got %0d want IDLE", dut.u_env1.state); else pass_cnt++;
        cycles(1);
        total_cnt++; if (dut.u_env1.state !== ATTACK) $display("FAIL keyon_latency: got %0d want ATTACK", dut.u_env1.state); else pass_cnt++;
        t0 = mticks;
        wait_env1(6'd63, 2000, ok);
        total_cnt++; if (!ok) $display("FAIL attack_timeout: env %0d never reached 63", dut.u_env1.env); else pass_cnt++;
        total_cnt++; if (mticks - t0 !== ATK_TICKS) $display("FAIL attack_ticks: got %0d want %0d", mticks - t0, ATK_TICKS); else pass_cnt++;
        cycles(2);
        total_cnt++; if (sample !== 12'(PRE_SAMPLE)) $display("FAIL attack_pipe: got %0d want %0d", sample, PRE_SAMPLE); else pass_cnt++;
        cycles(1);
        total_cnt++; if (sample !== 12'sd930) $display("FAIL attack_sample: got %0d want 930", sample); else pass_cnt++;
    endtask

    task automatic test_sign_sum;
        value2 = 4'd15;
        cycles(3);
        total_cnt++; if (sample !== 12'sd1860) $display("FAIL sum_pos: got %0d want 1860", sample); else pass_cnt++;
        neg1 = 1'b1;
        cycles(2);
        total_cnt++; if (sample !== 12'sd1860) $display("FAIL sum_latency: got %0d want 1860", sample); else pass_cnt++;
        cycles(1);
        total_cnt++; if (sample !== 12'sd0) $display("FAIL sum_cancel: got %0d want 0", sample); else pass_cnt++;
        neg2 = 1'b1;
        cycles(3);
        total_cnt++; if (sample !== -12'sd1860) $display("FAIL sum_neg: got %0d want -1860", sample); else pass_cnt++;
        neg1 = 1'b0; value2 = 4'd7;
        cycles(3);
        total_cnt++; if (sample !== 12'sd496) $display("FAIL sum_mixed: got %0d want 496", sample); else pass_cnt++;
    endtask

    task automatic test_total_level;
        neg1 = 1'b0; neg2 = 1'b0; value1 = 4'd15; value2 = 4'd15;
        write_reg(2, 2'b11, 8'd63);
        cycles(4);
        total_cnt++; if (sample !== 12'sd0) $display("FAIL tl_mute: got %0d want 0", sample); else pass_cnt++;
        value2 = 4'd0;
        write_reg(2, 2'b01, 8'd32);
        cycles(4);
        total_cnt++; if (sample !== 12'sd457) $display("FAIL tl_half: got %0d want 457", sample); else pass_cnt++;
    endtask

    task automatic test_decay_sustain;
        bit ok;
        int t0;
        do_reset;
        write_reg(0, 2'b11, 8'hFF);
        write_reg(1, 2'b11, 8'h80);
        value1 = 4'd15; value2 = 4'd0;
        play = 1'b1;
        wait_env1(6'd63, 2000, ok);
        total_cnt++; if (!ok) $display("FAIL decay_peak_timeout: env %0d never reached 63", dut.u_env1.env); else pass_cnt++;
        t0 = mticks;
        wait_state1(SUSTAIN, 2000, ok);
        total_cnt++; if (!ok) $display("FAIL decay_timeout: state %0d never SUSTAIN", dut.u_env1.state); else pass_cnt++;
        total_cnt++; if (mticks - t0 !== DEC_TICKS) $display("FAIL decay_ticks: got %0d want %0d", mticks - t0, DEC_TICKS); else pass_cnt++;
        total_cnt++; if (dut.u_env1.env !== 6'd31) $display("FAIL decay_target: got %0d want 31", dut.u_env1.env); else pass_cnt++;
        cycles(80);
        total_cnt++; if (dut.u_env1.state !== SUSTAIN) $display("FAIL sustain_hold_state: got %0d want SUSTAIN", dut.u_env1.state); else pass_cnt++;
        total_cnt++; if (dut.u_env1.env !== 6'd31) $display("FAIL sustain_hold_env: got %0d want 31", dut.u_env1.env); else pass_cnt++;
        total_cnt++; if (env_active !== 1'b1) $display("FAIL sustain_active: got %b want 1", env_active); else pass_cnt++;
        total_cnt++; if (sample !== 12'sd457) $display("FAIL sustain_sample: got %0d want 457", sample); else pass_cnt++;
    endtask

    task automatic test_release;
        bit ok;
        int t0;
        write_reg(1, 2'b11, 8'h8F);
        play = 1'b0;
        cycles(1);
        total_cnt++; if (dut.u_env1.state !== SUSTAIN) $display("FAIL keyoff_early: got %0d want SUSTAIN", dut.u_env1.state); else pass_cnt++;
        cycles(1);
        total_cnt++; if (dut.u_env1.state !== RELEASE) $display("FAIL keyoff_latency: got %0d want RELEASE", dut.u_env1.state); else pass_cnt++;
        t0 = mticks;
        wait_state1(IDLE, 2000, ok);
        total_cnt++; if (!ok) $display("FAIL release_timeout: state %0d never IDLE", dut.u_env1.state); else pass_cnt++;
        total_cnt++; if (mticks - t0 !== 31) $display("FAIL release_ticks: got %0d want 31", mticks - t0); else pass_cnt++;
        total_cnt++; if (dut.u_env1.env !== 6'd0) $display("FAIL release_env: got %0d want 0", dut.u_env1.env); else pass_cnt++;
        total_cnt++; if (env_active !== 1'b1) $display("FAIL release_active_lag: got %b want 1", env_active); else pass_cnt++;
        cycles(1);
        total_cnt++; if (env_active !== 1'b0) $display("FAIL release_active_fall: got %b want 0", env_active); else pass_cnt++;
        cycles(3);
        total_cnt++; if (sample !== 12'sd0) $display("FAIL release_sample: got %0d want 0", sample); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_attack;
        test_sign_sum;
        test_total_level;
        test_decay_sustain;
        test_release;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
